// File: rtl/jtag_func_sel_pkg.sv
// Shared JTAG user-channel definitions: default code widths, the daisy-chain code
// and the strobe code window used by the function-select block.
package jtag_func_sel_pkg;

    localparam int          FW_DEF        = 8;
    localparam int          NF_DEF        = 16;
    localparam logic [7:0]  DSY_CODE_DEF  = 8'h30;
    localparam logic [7:0]  STRB_BASE_DEF = 8'h3C;
    localparam int          N_STRB        = 4;

    // Which of the three actions an Update-DR performs for a given code.
    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_STRB  = 2'd2
    } upd_act_e;

endpackage

// File: rtl/jtag_code_dec.sv
// Combinational decode of an instruction code into a one-hot function select,
// a daisy-chain flag and strobe flags. Zero latency, no state.
module jtag_code_dec
    import jtag_func_sel_pkg::*;
#(
    parameter int             FW        = FW_DEF,
    parameter int             NF        = NF_DEF,
    parameter logic [FW-1:0]  DSY_CODE  = FW'(DSY_CODE_DEF),
    parameter logic [FW-1:0]  STRB_BASE = FW'(STRB_BASE_DEF)
) (
    input  logic [FW-1:0]     code,
    output logic [NF-1:0]     fsel,
    output logic              dsy,
    output logic              strb_hit,
    output logic [N_STRB-1:0] strb_vec
);

    logic [FW-1:0] strb_off;

    always_comb begin
        // Codes below the base wrap to large offsets and fall outside the window.
        strb_off = code - STRB_BASE;
        strb_hit = (strb_off < FW'(N_STRB));
        strb_vec = '0;
        if (strb_hit) begin
            strb_vec[strb_off[1:0]] = 1'b1;
        end
    end

    always_comb begin
        dsy  = (code == DSY_CODE);
        fsel = '0;
        // Daisy-chain mode wins so FSEL and DSY_CHAIN can never both be set.
        for (int k = 0; k < NF; k++) begin
            if (!dsy && (code == FW'(k + 1))) begin
                fsel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtag_func_sel.sv
// JTAG user-channel function selector: instruction register, latched function code,
// one-hot select / daisy-chain enable, single-cycle strobes and the TDO mux.
module jtag_func_sel
    import jtag_func_sel_pkg::*;
#(
    parameter int             FW        = FW_DEF,
    parameter int             NF        = NF_DEF,
    parameter logic [FW-1:0]  DSY_CODE  = FW'(DSY_CODE_DEF),
    parameter logic [FW-1:0]  STRB_BASE = FW'(STRB_BASE_DEF)
) (
    input  logic              TCK,
    input  logic              RST,
    input  logic              SEL_INS,
    input  logic              SEL_DAT,
    input  logic              TDI,
    input  logic              CAPTURE,
    input  logic              SHIFT,
    input  logic              UPDATE,
    input  logic [NF-1:0]     TDO_BUS,
    input  logic              DSY_TDO,
    output logic [NF-1:0]     FSEL,
    output logic              DSY_CHAIN,
    output logic [N_STRB-1:0] STRB,
    output logic [FW-1:0]     FCODE,
    output logic              TDO
);

    logic [FW-1:0]     ir_q,    ir_d;
    logic [FW-1:0]     fcode_q, fcode_d;
    logic [NF-1:0]     fsel_q,  fsel_d;
    logic              dsy_q,   dsy_d;
    logic [N_STRB-1:0] strb_q,  strb_d;

    logic              ins_act;
    logic              dat_act;
    upd_act_e          upd_act;

    logic [NF-1:0]     dec_fsel;
    logic              dec_dsy;
    logic              dec_strb_hit;
    logic [N_STRB-1:0] dec_strb_vec;

    // Both selects high is illegal and treated exactly like neither.
    assign ins_act = SEL_INS & ~SEL_DAT;
    assign dat_act = SEL_DAT & ~SEL_INS;

    jtag_code_dec #(
        .FW        (FW),
        .NF        (NF),
        .DSY_CODE  (DSY_CODE),
        .STRB_BASE (STRB_BASE)
    ) u_dec (
        .code      (ir_q),
        .fsel      (dec_fsel),
        .dsy       (dec_dsy),
        .strb_hit  (dec_strb_hit),
        .strb_vec  (dec_strb_vec)
    );

    always_comb begin
        upd_act = ACT_NONE;
        if (ins_act && UPDATE) begin
            upd_act = dec_strb_hit ? ACT_STRB : ACT_LOAD;
        end
    end

    always_comb begin
        ir_d = ir_q;
        if (ins_act) begin
            if (CAPTURE) begin
                ir_d = fcode_q;
            end else if (SHIFT) begin
                ir_d = {TDI, ir_q[FW-1:1]};
            end
        end
    end

    always_comb begin
        fcode_d = fcode_q;
        fsel_d  = fsel_q;
        dsy_d   = dsy_q;
        strb_d  = '0;
        case (upd_act)
            ACT_LOAD: begin
                fcode_d = ir_q;
                fsel_d  = dec_fsel;
                dsy_d   = dec_dsy;
            end
            ACT_STRB: begin
                strb_d  = dec_strb_vec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge TCK or posedge RST) begin
        if (RST) begin
            ir_q    <= '0;
            fcode_q <= '0;
            fsel_q  <= '0;
            dsy_q   <= 1'b0;
            strb_q  <= '0;
        end else begin
            ir_q    <= ir_d;
            fcode_q <= fcode_d;
            fsel_q  <= fsel_d;
            dsy_q   <= dsy_d;
            strb_q  <= strb_d;
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (ins_act) begin
            TDO = ir_q[0];
        end else if (dat_act) begin
            TDO = dsy_q ? DSY_TDO : |(fsel_q & TDO_BUS);
        end
    end

    assign FSEL      = fsel_q;
    assign DSY_CHAIN = dsy_q;
    assign STRB      = strb_q;
    assign FCODE     = fcode_q;

endmodule

// File: tb/tb_jtag_func_sel.sv
// Directed and randomized checks of jtag_func_sel against a code-level reference model.
module tb_jtag_func_sel;

    logic        TCK = 1'b0;
    logic        RST;
    logic        SEL_INS, SEL_DAT, TDI, CAPTURE, SHIFT, UPDATE;
    logic [15:0] TDO_BUS;
    logic        DSY_TDO;
    logic [15:0] FSEL;
    logic        DSY_CHAIN;
    logic [3:0]  STRB;
    logic [7:0]  FCODE;
    logic        TDO;

    int checks   = 0;
    int failures = 0;

    // Reference model: the IR as a number, the latched code, and the pending strobe.
    int unsigned m_ir;
    int unsigned m_fcode;
    logic [3:0]  m_strb;

    jtag_func_sel dut (
        .TCK       (TCK),
        .RST       (RST),
        .SEL_INS   (SEL_INS),
        .SEL_DAT   (SEL_DAT),
        .TDI       (TDI),
        .CAPTURE   (CAPTURE),
        .SHIFT     (SHIFT),
        .UPDATE    (UPDATE),
        .TDO_BUS   (TDO_BUS),
        .DSY_TDO   (DSY_TDO),
        .FSEL      (FSEL),
        .DSY_CHAIN (DSY_CHAIN),
        .STRB      (STRB),
        .FCODE     (FCODE),
        .TDO       (TDO)
    );

    always #5 TCK = ~TCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_fsel();
        if (m_fcode >= 1 && m_fcode <= 16 && m_fcode != 32'h30)
            return 16'(32'd1 << (m_fcode - 1));
        return 16'h0;
    endfunction

    function automatic logic exp_dsy();
        return m_fcode == 32'h30;
    endfunction

    function automatic logic exp_tdo();
        if (SEL_INS && !SEL_DAT) return m_ir[0];
        if (SEL_DAT && !SEL_INS) return exp_dsy() ? DSY_TDO : |(exp_fsel() & TDO_BUS);
        return 1'b0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_fcode"}, 32'(FCODE), m_fcode);
        check({tag, "_fsel"},  32'(FSEL), 32'(exp_fsel()));
        check({tag, "_dsy"},   32'(DSY_CHAIN), 32'(exp_dsy()));
        check({tag, "_strb"},  32'(STRB), 32'(m_strb));
        check({tag, "_tdo"},   32'(TDO), 32'(exp_tdo()));
    endtask

    function automatic void model_reset();
        m_ir = 0; m_fcode = 0; m_strb = 4'h0;
    endfunction

    function automatic void model_edge();
        int unsigned old_ir;
        old_ir = m_ir;
        m_strb = 4'h0;
        if (SEL_INS && !SEL_DAT) begin
            if (CAPTURE)    m_ir = m_fcode;
            else if (SHIFT) m_ir = (m_ir >> 1) | (int'(TDI) << 7);
            if (UPDATE) begin
                if (old_ir >= 32'h3C && old_ir <= 32'h3F) m_strb = 4'(32'd1 << (old_ir - 32'h3C));
                else m_fcode = old_ir;
            end
        end
    endfunction

    // One TCK cycle: inputs applied, TDO checked before the edge, all outputs after it.
    task automatic drive(input logic si, input logic sd, input logic tdi, input logic cap,
                         input logic sh, input logic upd, output logic tdo_seen);
        SEL_INS = si; SEL_DAT = sd; TDI = tdi; CAPTURE = cap; SHIFT = sh; UPDATE = upd;
        #1;
        tdo_seen = TDO;
        check("tdo_pre", 32'(TDO), 32'(exp_tdo()));
        @(posedge TCK);
        #1;
        model_edge();
        check_all("post");
    endtask

    task automatic shift_code(input logic [7:0] c);
        logic t;
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, c[i], 1'b0, 1'b1, 1'b0, t);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
    endtask

    task automatic idle();
        logic t;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, t);
    endtask

    initial begin
        logic       t;
        logic [7:0] seq;
        logic [7:0] code;
        int         kind;

        RST = 1'b1; SEL_INS = 0; SEL_DAT = 0; TDI = 0; CAPTURE = 0; SHIFT = 0; UPDATE = 0;
        TDO_BUS = 16'h0; DSY_TDO = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge TCK); #1;
        check_all("reset_held");
        RST = 1'b0;

        // Basic function select load.
        shift_code(8'h05);
        check("ld05_fcode", 32'(FCODE), 32'h05);
        check("ld05_fsel",  32'(FSEL), 32'h0010);
        check("ld05_strb",  32'(STRB), 32'h0);
        idle();

        // Data channel TDO through the selected function.
        SEL_DAT = 1'b1; SEL_INS = 1'b0; TDO_BUS = 16'h0010; #1;
        check("dat_tdo_sel", 32'(TDO), 32'h1);
        TDO_BUS = 16'hFFEF; #1;
        check("dat_tdo_unsel", 32'(TDO), 32'h0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, t);
        TDO_BUS = 16'h0;

        // Strobe code: one-cycle pulse, select unchanged.
        shift_code(8'h3E);
        check("strb_pulse", 32'(STRB), 32'h4);
        check("strb_fcode", 32'(FCODE), 32'h05);
        check("strb_fsel",  32'(FSEL), 32'h0010);
        idle();
        check("strb_gone", 32'(STRB), 32'h0);

        // Daisy-chain mode and capture readback.
        shift_code(8'h30);
        check("dsy_on",   32'(DSY_CHAIN), 32'h1);
        check("dsy_fsel", 32'(FSEL), 32'h0);
        SEL_INS = 1'b0; SEL_DAT = 1'b1; TDO_BUS = 16'hFFFF; DSY_TDO = 1'b1; #1;
        check("dsy_tdo1", 32'(TDO), 32'h1);
        DSY_TDO = 1'b0; #1;
        check("dsy_tdo0", 32'(TDO), 32'h0);
        TDO_BUS = 16'h0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t);
        seq = 8'b0011_0000;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, t);
            check($sformatf("readback_bit%0d", i), 32'(t), 32'(seq[i]));
        end

        // Asynchronous reset mid-shift discards the partial code.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, t);
        #3;
        RST = 1'b1;
        #1;
        model_reset();
        check("arst_fcode", 32'(FCODE), 32'h0);
        check("arst_fsel",  32'(FSEL), 32'h0);
        check("arst_dsy",   32'(DSY_CHAIN), 32'h0);
        check("arst_strb",  32'(STRB), 32'h0);
        check("arst_tdo",   32'(TDO), 32'h0);
        @(posedge TCK); #1;
        check_all("arst_held");
        RST = 1'b0;
        shift_code(8'h02);
        check("after_rst_fsel", 32'(FSEL), 32'h0002);

        // Unassigned code, then illegal dual select leaves IR alone.
        shift_code(8'h20);
        check("unasg_fcode", 32'(FCODE), 32'h20);
        check("unasg_fsel",  32'(FSEL), 32'h0);
        check("unasg_dsy",   32'(DSY_CHAIN), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, t);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, t);
            check("illegal_tdo", 32'(t), 32'h0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t);
        check("illegal_ir_kept", 32'(FCODE), 32'h20);

        // Randomized code loads with odd shift lengths and noisy cycles in between.
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 3));
            case (kind)
                0:       code = 8'($urandom_range(0, 255));
                1:       code = 8'(8'h3C + $urandom_range(0, 3));
                2:       code = 8'($urandom_range(0, 17));
                default: code = 8'h30;
            endcase
            for (int i = 0; i < int'($urandom_range(0, 4)); i++)
                drive(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0, t);
            shift_code(code);
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                TDO_BUS = 16'($urandom);
                DSY_TDO = 1'($urandom);
                drive(1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0), 1'($urandom),
                      ($urandom_range(0, 3) == 0), t);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
